// File: rtl/apb_master_bridge.sv
// APB requester: one host transfer at a time, SETUP/ACCESS sequencing, two-slave decode.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_write,
  input  logic [ADDR_WIDTH:0]   host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSEL1,
  output logic                  PSEL2,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA1,
  input  logic [DATA_WIDTH-1:0] PRDATA2,
  input  logic                  PREADY1,
  input  logic                  PREADY2
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_e                state_q, state_d;
  logic                  psel1_q, psel1_d;
  logic                  psel2_q, psel2_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_rdata;
`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
`endif

  // Only the addressed slave's handshake matters; the other one is ignored.
  assign sel_ready = psel2_q ? PREADY2 : PREADY1;
  assign sel_rdata = psel2_q ? PRDATA2 : PRDATA1;

  always_comb begin
    state_d     = state_q;
    psel1_d     = psel1_q;
    psel2_d     = psel2_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (host_valid) begin
          state_d  = SETUP;
          psel1_d  = ~host_addr[ADDR_WIDTH];
          psel2_d  = host_addr[ADDR_WIDTH];
          pwrite_d = host_write;
          paddr_d  = host_addr[ADDR_WIDTH-1:0];
          pwdata_d = host_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (sel_ready) begin
          state_d     = IDLE;
          psel1_d     = 1'b0;
          psel2_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
        end
`ifdef APB_TIMEOUT_EN
        else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          // Abort on the wait cycle that brings the count up to the limit.
          if (wait_cnt_d == TIMEOUT_LIMIT) begin
            state_d     = IDLE;
            psel1_d     = 1'b0;
            psel2_d     = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel1_q     <= 1'b0;
      psel2_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel1_q     <= psel1_d;
      psel2_q     <= psel2_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign host_ready = (state_q == IDLE);
  assign PSEL1      = psel1_q;
  assign PSEL2      = psel2_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: vector table of single transfers plus
// reset-abort, back-to-back and (with APB_TIMEOUT_EN) timeout sequences.
module tb_apb_master_bridge;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       host_valid, host_ready, host_write;
  logic [8:0] host_addr;
  logic [7:0] host_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA, PRDATA1, PRDATA2;
  logic       PREADY1, PREADY2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .host_valid(host_valid), .host_ready(host_ready), .host_write(host_write),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY1(PREADY1), .PREADY2(PREADY2)
  );

  typedef struct {
    logic       write;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] prdata1;
    logic [7:0] prdata2;
    int         waits;
    logic       other_ready;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic set_ready(input logic sel2, input logic sel_rdy, input logic oth);
    if (sel2) begin PREADY2 = sel_rdy; PREADY1 = oth; end
    else      begin PREADY1 = sel_rdy; PREADY2 = oth; end
  endtask

  task automatic run_vec(input vec_t v);
    logic sel2;
    sel2 = v.addr[8];
    chk("ready_before", 32'(host_ready), 32'd1);
    host_valid = 1'b1; host_write = v.write; host_addr = v.addr; host_wdata = v.wdata;
    PRDATA1 = v.prdata1; PRDATA2 = v.prdata2;
    set_ready(sel2, 1'b0, v.other_ready);
    step();
    host_valid = 1'b0;
    chk("setup_psel1", 32'(PSEL1), 32'(!sel2));
    chk("setup_psel2", 32'(PSEL2), 32'(sel2));
    chk("setup_penable", 32'(PENABLE), 32'd0);
    chk("setup_pwrite", 32'(PWRITE), 32'(v.write));
    chk("setup_paddr", 32'(PADDR), 32'(v.addr[7:0]));
    chk("setup_pwdata", 32'(PWDATA), 32'(v.wdata));
    chk("setup_host_ready", 32'(host_ready), 32'd0);
    set_ready(sel2, v.waits == 0, v.other_ready);
    step();
    chk("access_penable", 32'(PENABLE), 32'd1);
    chk("access_psel", 32'({PSEL2, PSEL1}), sel2 ? 32'd2 : 32'd1);
    for (int i = 0; i < v.waits; i++) begin
      step();
      chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("wait_penable", 32'(PENABLE), 32'd1);
      chk("wait_paddr", 32'(PADDR), 32'(v.addr[7:0]));
      set_ready(sel2, i == v.waits - 1, v.other_ready);
    end
    step();
    set_ready(sel2, 1'b0, 1'b0);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_rdata", 32'(rsp_rdata), 32'(v.exp_rdata));
    chk("rsp_err", 32'(rsp_err), 32'd0);
    chk("done_psel", 32'({PSEL2, PSEL1, PENABLE}), 32'd0);
    chk("done_host_ready", 32'(host_ready), 32'd1);
    step();
    chk("rsp_pulse_end", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [8:0] b2b_addr [3];
    vecs[0] = '{1'b1, 9'h005, 8'hA5, 8'h11, 8'h22, 0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 9'h10A, 8'h00, 8'h55, 8'h3C, 2, 1'b0, 8'h3C};
    vecs[2] = '{1'b0, 9'h033, 8'h00, 8'hC7, 8'h99, 3, 1'b1, 8'hC7};
    vecs[3] = '{1'b1, 9'h1FF, 8'h5A, 8'h77, 8'h66, 1, 1'b1, 8'h00};
    vecs[4] = '{1'b0, 9'h0FF, 8'h00, 8'h81, 8'hE4, 0, 1'b1, 8'h81};
    b2b_addr[0] = 9'h011; b2b_addr[1] = 9'h122; b2b_addr[2] = 9'h033;

    PRESET = 1'b1; host_valid = 1'b0; host_write = 1'b0; host_addr = '0; host_wdata = '0;
    PRDATA1 = '0; PRDATA2 = '0; PREADY1 = 1'b0; PREADY2 = 1'b0;
    step(); step();
    chk("reset_apb", 32'({PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA}), 32'd0);
    chk("reset_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'd0);
    chk("reset_host_ready", 32'(host_ready), 32'd1);
    PRESET = 1'b0;
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a stalled ACCESS aborts without a response.
    host_valid = 1'b1; host_write = 1'b1; host_addr = 9'h1C3; host_wdata = 8'hEE;
    PREADY1 = 1'b0; PREADY2 = 1'b0;
    step(); host_valid = 1'b0;
    step();
    chk("pre_reset_access", 32'({PSEL2, PENABLE}), 32'd3);
    PRESET = 1'b1;
    PREADY2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("midrst_apb", 32'({PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA}), 32'd0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_host_ready", 32'(host_ready), 32'd1);
    end
    PRESET = 1'b0; PREADY2 = 1'b0;
    step();
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_rst_psel", 32'({PSEL1, PSEL2, PENABLE}), 32'd0);

    // Back-to-back reads with zero wait states: one response every third cycle.
    PRDATA1 = 8'h4D; PRDATA2 = 8'hB2; PREADY1 = 1'b1; PREADY2 = 1'b1;
    host_valid = 1'b1; host_write = 1'b0; host_addr = b2b_addr[0];
    for (int cyc = 1; cyc <= 9; cyc++) begin
      step();
      chk("b2b_rsp_valid", 32'(rsp_valid), 32'(cyc % 3 == 0));
      chk("b2b_host_ready", 32'(host_ready), 32'(cyc % 3 == 0));
      chk("b2b_psel_any", 32'(PSEL1 | PSEL2), 32'(cyc % 3 != 0));
      if (cyc % 3 == 1) chk("b2b_paddr", 32'(PADDR), 32'(b2b_addr[cyc / 3][7:0]));
      if (cyc % 3 == 0) begin
        chk("b2b_rdata", 32'(rsp_rdata), b2b_addr[cyc / 3 - 1][8] ? 32'h B2 : 32'h4D);
        if (cyc / 3 < 3) host_addr = b2b_addr[cyc / 3];
        else host_valid = 1'b0;
      end
    end
    PREADY1 = 1'b0; PREADY2 = 1'b0;
    step();

`ifdef APB_TIMEOUT_EN
    // Stalled slave: abort after four ACCESS cycles with an error response.
    PRDATA1 = 8'h6B;
    host_valid = 1'b1; host_write = 1'b0; host_addr = 9'h044;
    step(); host_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_access", 32'({PENABLE, rsp_valid}), 32'd2);
    end
    step();
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("to_psel", 32'({PSEL1, PSEL2, PENABLE}), 32'd0);
    step();
    run_vec(vecs[1]);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
